preamble_inserter: RTL and testbench

Transmit-side framer for the OFDM modem: on the first pending payload sample, it emits a fixed BPSK training preamble of N_REPEAT identical short symbols, then forwards the complex payload stream unchanged. The receiver's preamble detector and adaptive threshold filter lock onto this preamble. It sits between the TX IFFT/cyclic-prefix stage and the DAC interface, with valid/ready handshakes on both sides.

---
 rtl/ofdm_tx_pkg.sv | 21 ++
 rtl/preamble_inserter_if.sv | 35 +++
 rtl/preamble_inserter_rom.sv | 26 ++
 rtl/preamble_inserter.sv | 160 ++++++++++++++++
 tb/tb_preamble_inserter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ofdm_tx_pkg.sv
// ofdm_tx_pkg: shared definitions for the OFDM transmit framer.
//   - pi_state_e           : preamble_inserter FSM states
//   - PREAMBLE_SEQ_DEFAULT : BPSK sign pattern of the short training symbol (LSB = sample 0)
//   - PREAMBLE_AMP_DEFAULT : preamble magnitude on I
// The RX preamble detector imports the same constants so both ends agree on the preamble.
// Optional build macro: PREAMBLE_INSERTER_GAP_EN adds the StGap state.
package ofdm_tx_pkg;

    localparam logic [15:0]     PREAMBLE_SEQ_DEFAULT = 16'hB38F;
    localparam int unsigned     PREAMBLE_AMP_DEFAULT = 8192;

    typedef enum logic [1:0] {
        StIdle,
        StPreamble,
        StPayload
`ifdef PREAMBLE_INSERTER_GAP_EN
        , StGap
`endif
    } pi_state_e;

endpackage

// File: rtl/preamble_inserter_if.sv
// preamble_inserter_if: payload-in and sample-out valid/ready streams of the framer.
//   in_re/in_im/in_valid/in_last  : payload sample from the IFFT/CP stage
//   in_ready                      : payload accept (combinational from the framer)
//   out_re/out_im/out_valid       : registered sample towards the DAC interface
//   out_sof/out_last              : first preamble sample / final sample of a frame
//   out_ready                     : DAC-side accept
// Modports: slave = framer side, master = surrounding logic driving payload and sinking output.
interface preamble_inserter_if #(
    parameter int unsigned DATA_SIZE = 16
);

    logic signed [DATA_SIZE-1:0] in_re;
    logic signed [DATA_SIZE-1:0] in_im;
    logic                        in_valid;
    logic                        in_last;
    logic                        in_ready;

    logic signed [DATA_SIZE-1:0] out_re;
    logic signed [DATA_SIZE-1:0] out_im;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_sof;
    logic                        out_last;

    modport slave (
        input  in_re, in_im, in_valid, in_last, out_ready,
        output in_ready, out_re, out_im, out_valid, out_sof, out_last
    );

    modport master (
        output in_re, in_im, in_valid, in_last, out_ready,
        input  in_ready, out_re, out_im, out_valid, out_sof, out_last
    );

endinterface

// File: rtl/preamble_inserter_rom.sv
// preamble_rom: combinational lookup of one short-training-symbol sample.
//   sym_idx_i : sample index within the short symbol
//   re_o      : +PREAMBLE_AMP when PREAMBLE_SEQ[sym_idx_i] is 1, else -PREAMBLE_AMP
//   im_o      : always 0 (BPSK on I only)
module preamble_rom
    import ofdm_tx_pkg::*;
#(
    parameter int unsigned               DATA_SIZE    = 16,
    parameter int unsigned               PREAMBLE_LEN = 16,
    parameter logic [PREAMBLE_LEN-1:0]   PREAMBLE_SEQ = PREAMBLE_LEN'(PREAMBLE_SEQ_DEFAULT),
    parameter int unsigned               PREAMBLE_AMP = PREAMBLE_AMP_DEFAULT
) (
    input  logic [$clog2(PREAMBLE_LEN)-1:0] sym_idx_i,
    output logic signed [DATA_SIZE-1:0]     re_o,
    output logic signed [DATA_SIZE-1:0]     im_o
);

    localparam logic signed [DATA_SIZE-1:0] AmpPos = DATA_SIZE'(PREAMBLE_AMP);
    localparam logic signed [DATA_SIZE-1:0] AmpNeg = -AmpPos;

    always_comb begin
        re_o = PREAMBLE_SEQ[sym_idx_i] ? AmpPos : AmpNeg;
        im_o = '0;
    end

endmodule

// File: rtl/preamble_inserter.sv
// preamble_inserter: TX framer placing a BPSK training preamble of N_REPEAT short symbols
// ahead of each payload frame, then forwarding the payload unchanged.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset; abandons any frame in progress
//   en    : clock enable; when low nothing updates and nothing transfers
//   bus   : preamble_inserter_if.slave (payload in, framed samples out)
//   busy  : FSM not idle
// Build macro PREAMBLE_INSERTER_GAP_EN: append GAP_LEN zero samples after each frame and move
// out_last onto the final gap sample.
module preamble_inserter
    import ofdm_tx_pkg::*;
#(
    parameter int unsigned             DATA_SIZE    = 16,
    parameter int unsigned             PREAMBLE_LEN = 16,
    parameter int unsigned             N_REPEAT     = 10,
    parameter logic [PREAMBLE_LEN-1:0] PREAMBLE_SEQ = PREAMBLE_LEN'(PREAMBLE_SEQ_DEFAULT),
    parameter int unsigned             PREAMBLE_AMP = PREAMBLE_AMP_DEFAULT
`ifdef PREAMBLE_INSERTER_GAP_EN
    , parameter int unsigned           GAP_LEN      = 32
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    preamble_inserter_if.slave  bus,
    output logic                busy
);

    localparam int unsigned      IdxW    = $clog2(PREAMBLE_LEN);
    localparam logic [IdxW-1:0]  IdxLast = IdxW'(PREAMBLE_LEN - 1);
    localparam logic [7:0]       RepLast = 8'(N_REPEAT - 1);
`ifdef PREAMBLE_INSERTER_GAP_EN
    localparam int unsigned      GapW    = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam logic [GapW-1:0]  GapLast = GapW'(GAP_LEN - 1);
    logic [GapW-1:0]             gap_cnt_q;
`endif

    pi_state_e                   state_q;
    logic [IdxW-1:0]             sym_idx_q;
    logic [7:0]                  rep_cnt_q;
    logic signed [DATA_SIZE-1:0] out_re_q;
    logic signed [DATA_SIZE-1:0] out_im_q;
    logic                        out_valid_q;
    logic                        out_sof_q;
    logic                        out_last_q;
    logic signed [DATA_SIZE-1:0] rom_re;
    logic signed [DATA_SIZE-1:0] rom_im;
    logic                        load;

    // sym_idx_q is 0 whenever the FSM is idle, so the ROM already presents sample 0 there.
    preamble_rom #(
        .DATA_SIZE    (DATA_SIZE),
        .PREAMBLE_LEN (PREAMBLE_LEN),
        .PREAMBLE_SEQ (PREAMBLE_SEQ),
        .PREAMBLE_AMP (PREAMBLE_AMP)
    ) u_rom (
        .sym_idx_i (sym_idx_q),
        .re_o      (rom_re),
        .im_o      (rom_im)
    );

    assign load         = en && (!out_valid_q || bus.out_ready);
    assign bus.in_ready = load && (state_q == StPayload);
    assign busy         = (state_q != StIdle);

    assign bus.out_re    = out_re_q;
    assign bus.out_im    = out_im_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_last  = out_last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sym_idx_q   <= '0;
            rep_cnt_q   <= '0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef PREAMBLE_INSERTER_GAP_EN
            gap_cnt_q   <= '0;
`endif
        end else if (load) begin
            unique case (state_q)
                StIdle: begin
                    out_last_q <= 1'b0;
                    if (bus.in_valid) begin
                        // Sample 0 goes out now; the payload sample waits for StPayload.
                        out_valid_q <= 1'b1;
                        out_re_q    <= rom_re;
                        out_im_q    <= rom_im;
                        out_sof_q   <= 1'b1;
                        sym_idx_q   <= IdxW'(1);
                        rep_cnt_q   <= '0;
                        state_q     <= StPreamble;
                    end else begin
                        out_valid_q <= 1'b0;
                        out_sof_q   <= 1'b0;
                    end
                end
                StPreamble: begin
                    out_valid_q <= 1'b1;
                    out_re_q    <= rom_re;
                    out_im_q    <= rom_im;
                    out_sof_q   <= 1'b0;
                    out_last_q  <= 1'b0;
                    sym_idx_q   <= sym_idx_q + IdxW'(1);
                    if (sym_idx_q == IdxLast) begin
                        rep_cnt_q <= rep_cnt_q + 8'd1;
                        if (rep_cnt_q == RepLast) begin
                            state_q <= StPayload;
                        end
                    end
                end
                StPayload: begin
                    out_sof_q <= 1'b0;
                    if (bus.in_valid) begin
                        out_valid_q <= 1'b1;
                        out_re_q    <= bus.in_re;
                        out_im_q    <= bus.in_im;
`ifdef PREAMBLE_INSERTER_GAP_EN
                        out_last_q  <= 1'b0;
                        if (bus.in_last) begin
                            gap_cnt_q <= '0;
                            state_q   <= StGap;
                        end
`else
                        out_last_q  <= bus.in_last;
                        if (bus.in_last) begin
                            state_q <= StIdle;
                        end
`endif
                    end else begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                end
`ifdef PREAMBLE_INSERTER_GAP_EN
                StGap: begin
                    out_valid_q <= 1'b1;
                    out_re_q    <= '0;
                    out_im_q    <= '0;
                    out_sof_q   <= 1'b0;
                    gap_cnt_q   <= gap_cnt_q + GapW'(1);
                    out_last_q  <= (gap_cnt_q == GapLast);
                    if (gap_cnt_q == GapLast) begin
                        state_q <= StIdle;
                    end
                end
`endif
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_preamble_inserter.sv
// tb_preamble_inserter: self-checking bench for preamble_inserter (default parameters).
// Works for both builds; define PREAMBLE_INSERTER_GAP_EN for the gap variant.
`timescale 1ns/1ps
module tb_preamble_inserter;

    localparam int DW  = 16;
    localparam int PRE = 160;
`ifdef PREAMBLE_INSERTER_GAP_EN
    localparam int GAP = 32;
`else
    localparam int GAP = 0;
`endif

    typedef struct {
        int re;
        int im;
        bit sof;
        bit last;
    } samp_t;

    typedef struct {
        int re;
        int im;
        bit last;
    } in_t;

    typedef struct {
        int    idx;
        samp_t s;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    preamble_inserter_if #(.DATA_SIZE(DW)) bus ();

    preamble_inserter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus),
        .busy  (busy)
    );

    samp_t exp_q[$];
    in_t   tx_q[$];
    samp_t cap[$];
    bit    capturing    = 1'b0;
    int    vectors      = 0;
    int    miscompares  = 0;
    int    frame_xfers  = 0;
    int    acc_in_frame = 0;
    bit    last_acc     = 1'b0;
    bit    hold_pending = 1'b0;
    samp_t hold;
    bit    hold_valid;

    task automatic check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pre_val(int k);
        logic [15:0] seq;
        seq = 16'hB38F;
        return seq[k % 16] ? 8192 : -8192;
    endfunction

    // Reference: every frame is PRE preamble samples, the payload, then GAP zero samples.
    task automatic enqueue_frame(int n, bit rnd);
        int re, im;
        for (int k = 0; k < PRE; k++) exp_q.push_back('{pre_val(k), 0, k == 0, 1'b0});
        for (int i = 0; i < n; i++) begin
            re = rnd ? int'($urandom_range(0, 65535)) - 32768 : 2 * i + 1;
            im = rnd ? int'($urandom_range(0, 65535)) - 32768 : 2 * i + 2;
            tx_q.push_back('{re, im, i == n - 1});
            exp_q.push_back('{re, im, 1'b0, (i == n - 1) && (GAP == 0)});
        end
        for (int g = 0; g < GAP; g++) exp_q.push_back('{0, 0, 1'b0, g == GAP - 1});
    endtask

    task automatic sample();
        bit    xfer, acc;
        int    l;
        samp_t got, e;
        xfer = bus.out_valid && bus.out_ready && en;
        acc  = bus.in_valid && bus.in_ready && en;
        got  = '{int'($signed(bus.out_re)), int'($signed(bus.out_im)), bus.out_sof, bus.out_last};
        if (hold_pending) begin
            check("hold_valid", int'(bus.out_valid), int'(hold_valid));
            check("hold_re", got.re, hold.re);
            check("hold_im", got.im, hold.im);
            check("hold_sof", int'(got.sof), int'(hold.sof));
            check("hold_last", int'(got.last), int'(hold.last));
        end
        hold_pending = bus.out_valid && !xfer;
        hold         = got;
        hold_valid   = bus.out_valid;
        if (!en) check("ready_when_disabled", int'(bus.in_ready), 0);
        // Loaded-so-far in this frame must equal preamble plus accepted payload when ready.
        l = frame_xfers + (bus.out_valid ? 1 : 0);
        if (bus.in_ready) check("ready_phase", int'(l == PRE + acc_in_frame && !last_acc), 1);
        if (acc) begin
            acc_in_frame++;
            if (bus.in_last) last_acc = 1'b1;
            if (tx_q.size() > 0) void'(tx_q.pop_front());
        end
        if (xfer) begin
            if (capturing) cap.push_back(got);
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_re", got.re, e.re);
                check("out_im", got.im, e.im);
                check("out_sof", int'(got.sof), int'(e.sof));
                check("out_last", int'(got.last), int'(e.last));
            end
            frame_xfers++;
            if (got.last) begin
                frame_xfers  = 0;
                acc_in_frame = 0;
                last_acc     = 1'b0;
            end
        end
    endtask

    // Called at a falling edge: drive inputs, sample 1 ns later, wait for next falling edge.
    task automatic cycle(int pv, int pr);
        bus.in_valid = (tx_q.size() > 0) && ($urandom_range(0, 99) < pv);
        if (tx_q.size() > 0) begin
            bus.in_re   = DW'(tx_q[0].re);
            bus.in_im   = DW'(tx_q[0].im);
            bus.in_last = tx_q[0].last;
        end else begin
            bus.in_re   = '0;
            bus.in_im   = '0;
            bus.in_last = 1'b0;
        end
        bus.out_ready = ($urandom_range(0, 99) < pr);
        #1;
        sample();
        @(negedge clk);
    endtask

    task automatic drain(int pv, int pr);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || tx_q.size() > 0) && n < 8000) begin
            cycle(pv, pr);
            n++;
        end
        check("drain_remaining", exp_q.size(), 0);
    endtask

    vec_t tbl[13];

    initial begin
        int n;
        int fx;

        bus.in_valid  = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        tbl[0]  = '{0,   '{8192, 0, 1'b1, 1'b0}};
        tbl[1]  = '{3,   '{8192, 0, 1'b0, 1'b0}};
        tbl[2]  = '{4,   '{-8192, 0, 1'b0, 1'b0}};
        tbl[3]  = '{6,   '{-8192, 0, 1'b0, 1'b0}};
        tbl[4]  = '{7,   '{8192, 0, 1'b0, 1'b0}};
        tbl[5]  = '{10,  '{-8192, 0, 1'b0, 1'b0}};
        tbl[6]  = '{16,  '{8192, 0, 1'b0, 1'b0}};
        tbl[7]  = '{20,  '{-8192, 0, 1'b0, 1'b0}};
        tbl[8]  = '{159, '{8192, 0, 1'b0, 1'b0}};
        tbl[9]  = '{160, '{1, 2, 1'b0, 1'b0}};
        tbl[10] = '{161, '{3, 4, 1'b0, 1'b0}};
        tbl[11] = '{163, '{7, 8, 1'b0, GAP == 0}};
        tbl[12] = '{PRE + 3 + GAP, '{(GAP == 0) ? 7 : 0, (GAP == 0) ? 8 : 0, 1'b0, 1'b1}};

        // Reset state
        @(negedge clk);
        #1;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_re", int'(bus.out_re), 0);
        check("rst_out_im", int'(bus.out_im), 0);
        check("rst_out_sof", int'(bus.out_sof), 0);
        check("rst_out_last", int'(bus.out_last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(bus.in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        @(negedge clk);

        // Basic frame, checked against the hand-derived table
        capturing = 1'b1;
        enqueue_frame(4, 1'b0);
        drain(100, 100);
        capturing = 1'b0;
        check("basic_count", cap.size(), PRE + 4 + GAP);
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].idx < cap.size()) begin
                check("tbl_re", cap[tbl[i].idx].re, tbl[i].s.re);
                check("tbl_im", cap[tbl[i].idx].im, tbl[i].s.im);
                check("tbl_sof", int'(cap[tbl[i].idx].sof), int'(tbl[i].s.sof));
                check("tbl_last", int'(cap[tbl[i].idx].last), int'(tbl[i].s.last));
            end
        end
        repeat (3) cycle(0, 100);
        check("idle_busy", int'(busy), 0);
        check("idle_out_valid", int'(bus.out_valid), 0);

        // Back-to-back random frames with backpressure and input bubbles
        for (int b = 0; b < 2; b++) begin
            for (int f = 0; f < 3; f++) enqueue_frame(int'($urandom_range(1, 8)), 1'b1);
            drain(60, 50);
        end

        // Clock enable held low mid-payload
        enqueue_frame(6, 1'b1);
        n = 0;
        while (acc_in_frame < 2 && n < 400) begin
            cycle(100, 100);
            n++;
        end
        check("reach_payload", int'(acc_in_frame >= 2), 1);
        fx = frame_xfers;
        en = 1'b0;
        repeat (5) cycle(100, 100);
        check("freeze_no_xfer", frame_xfers, fx);
        en = 1'b1;
        drain(100, 100);

        // Asynchronous reset at preamble sample 50
        enqueue_frame(4, 1'b1);
        n = 0;
        while (frame_xfers < 50 && n < 400) begin
            cycle(100, 100);
            n++;
        end
        check("reach_sample50", frame_xfers, 50);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", int'(bus.out_valid), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_out_sof", int'(bus.out_sof), 0);
        check("arst_out_re", int'(bus.out_re), 0);
        exp_q.delete();
        tx_q.delete();
        frame_xfers  = 0;
        acc_in_frame = 0;
        last_acc     = 1'b0;
        hold_pending = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        enqueue_frame(3, 1'b1);
        drain(80, 70);

        repeat (3) cycle(0, 100);
        check("end_busy", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
